// File: rtl/rsa_exp_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_exp_ctrl
//
// Host-side controller for a 1024-bit modular exponentiation core. It takes
// 129 host words: 32 words each for msg, n, rmodn and r2modn, least
// significant word first, then one word whose low half is the exponent. It
// then pulses exp_start once and waits for exp_done. The 1024-bit result is
// streamed back to the host as 32 words, least significant first. m_last
// marks the final word.
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               asynchronous, active-high; clears all state
//   s_data/s_valid      host load stream; s_ready is high only while loading
//   m_data/m_valid      result stream; the host accepts a word with m_ready
//   m_last              high on result word 31
//   busy                high from the start pulse to the last result handshake
//   exp_start           one-cycle start pulse to the core
//   exp_msg, exp_n,
//   exp_rmodn, exp_r2modn, exp_e   operand registers to the core
//   exp_result/exp_done core result, sampled only while waiting for the core
// -----------------------------------------------------------------------------
module rsa_exp_ctrl (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [31:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          exp_start,
    output logic [1023:0] exp_msg,
    output logic [1023:0] exp_n,
    output logic [1023:0] exp_rmodn,
    output logic [1023:0] exp_r2modn,
    output logic [15:0]   exp_e,
    input  logic [1023:0] exp_result,
    input  logic          exp_done
);

    localparam int DATA_W = 32;
    localparam int OPER_W = 1024;
    localparam int E_W    = 16;

    localparam logic [7:0] EXP_SLOT  = 8'd128;
    localparam logic [4:0] LAST_WORD = 5'd31;

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [7:0]        widx;
    logic [4:0]        k;
    logic              live;
    logic [OPER_W-1:0] result;

    logic              load_fire;
    logic              drain_fire;
    logic [9:0]        load_lsb;
    logic [9:0]        drain_lsb;

    // The state register is LOAD during reset, but s_ready must stay low
    // until the first clock after reset releases. This flag provides that
    // one-cycle hold-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign s_ready    = (state == LOAD) && live;
    assign m_valid    = (state == DRAIN);
    assign m_last     = (state == DRAIN) && (k == LAST_WORD);
    assign busy       = (state != LOAD);
    assign exp_start  = (state == START);

    assign load_fire  = s_valid && s_ready;
    assign drain_fire = m_valid && m_ready;

    // Bit offset of the 32-bit word inside its 1024-bit operand or result.
    assign load_lsb   = {widx[4:0], 5'd0};
    assign drain_lsb  = {k, 5'd0};

    // m_data depends only on k, so it stays stable while the host stalls.
    assign m_data     = result[drain_lsb +: DATA_W];

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (load_fire && (widx == EXP_SLOT)) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (exp_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_fire && (k == LAST_WORD)) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Word counter. The exponent slot is the last one, so it wraps to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            widx <= 8'd0;
        end else if (load_fire) begin
            if (widx == EXP_SLOT) begin
                widx <= 8'd0;
            end else begin
                widx <= widx + 8'd1;
            end
        end
    end

    // Drain counter. After word 31 it wraps back to 0 by itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= 5'd0;
        end else if (drain_fire) begin
            k <= k + 5'd1;
        end
    end

    // Operand registers. They are written only on load handshakes, so they
    // hold steady for the whole exponentiation and drain. They keep their
    // values after a run; the next load overwrites every slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_msg    <= '0;
            exp_n      <= '0;
            exp_rmodn  <= '0;
            exp_r2modn <= '0;
            exp_e      <= '0;
        end else if (load_fire) begin
            if (widx[7]) begin
                // Only slot 128 has bit 7 set. The upper half of that
                // word is dropped.
                exp_e <= s_data[E_W-1:0];
            end else begin
                case (widx[6:5])
                    2'd0:    exp_msg[load_lsb +: DATA_W]    <= s_data;
                    2'd1:    exp_n[load_lsb +: DATA_W]      <= s_data;
                    2'd2:    exp_rmodn[load_lsb +: DATA_W]  <= s_data;
                    default: exp_r2modn[load_lsb +: DATA_W] <= s_data;
                endcase
            end
        end
    end

    // The core result is valid only in its exp_done cycle. Capture it then.
    // exp_done is ignored in every state except WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= '0;
        end else if ((state == WAIT) && exp_done) begin
            result <= exp_result;
        end
    end

endmodule

// File: doc/rsa_exp_ctrl.md
RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 s_data  input  32  host load word.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_ready  output  1  block accepts s_data.
REQ-007 m_data  output  32  result word to host.
REQ-008 m_valid  output  1  m_data valid.
REQ-009 m_ready  input  1  host accepts m_data.
REQ-010 m_last  output  1  marks final result word.
REQ-011 busy  output  1  high from exp_start until the last result word handshake.
REQ-012 exp_start  output  1  one-cycle start pulse to the exponentiation core.
REQ-013 exp_msg, exp_n, exp_rmodn, exp_r2modn  output  1024 each  operand registers to the core.
REQ-014 exp_e  output  16  exponent to the core.
REQ-015 exp_result  input  1024  core result; valid in the exp_done cycle.
REQ-016 exp_done  input  1  core completion flag.

Function
REQ-017 The FSM SHALL have exactly four states: LOAD, START, WAIT and DRAIN.
REQ-018 Counter widths SHALL be: word counter widx 8 bits; drain counter 5 bits.
REQ-019 LOAD: s_ready=1; each s_valid&&s_ready handshake writes s_data into slot widx, then widx increments.
REQ-020 Slot map: widx 0-31 msg, 32-63 n, 64-95 rmodn, 96-127 r2modn, each least-significant word first; widx 128 loads s_data[15:0] into exp_e; s_data[31:16] of that word is ignored.
REQ-021 On the widx-128 handshake the FSM SHALL go to START, and widx SHALL wrap to 0.
REQ-022 START: exp_start=1 for exactly one cycle, s_ready=0; next state WAIT; busy rises with exp_start.
REQ-023 Latency: last load handshake in cycle T gives exp_start=1 in cycle T+1.
REQ-024 exp_msg, exp_n, exp_rmodn, exp_r2modn and exp_e SHALL stay constant from START until DRAIN completes.
REQ-025 Operand registers SHALL be retained after a run, not cleared; each run overwrites them fully.
REQ-026 WAIT: when exp_done=1, capture exp_result into the result register and go to DRAIN.
REQ-027 exp_done SHALL be ignored in LOAD, START and DRAIN, including when it coincides with exp_start.
REQ-028 WAIT has no timeout; the block SHALL wait indefinitely.
REQ-029 Latency: exp_done in cycle D gives m_valid=1 with result word 0 in cycle D+1.
REQ-030 DRAIN: m_valid=1 and m_data = result[32k+31:32k] for drain count k, starting at k=0; k increments on m_valid&&m_ready.
REQ-031 m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-032 m_last SHALL be 1 only when k=31 in DRAIN.
REQ-033 After the k=31 handshake: go to LOAD, k=0, busy=0, s_ready=1 in the following cycle.
REQ-034 s_ready and m_valid SHALL never both be 1.
REQ-035 s_valid outside LOAD SHALL be ignored, with no write and no counter change.

Reset
REQ-036 While reset=1, all outputs SHALL read 0: s_ready, m_valid, m_last, busy, exp_start, m_data, exp_e and all operand buses.
REQ-037 While reset=1, the FSM SHALL be in LOAD and widx and k SHALL be 0.
REQ-038 s_ready SHALL become 1 in the first clock after reset deasserts.
REQ-039 Reset in any state, mid-load or mid-drain, SHALL discard partial operands and results; no exp_start SHALL follow.

Verification
REQ-040 Load msg=2, n=1024'hF7 (247), rmodn=1, r2modn=1, exp=16'h0003 (129 words, s_valid held high) -> exactly one exp_start pulse, one cycle after word 128, with operand buses equal to the loaded values.
REQ-041 A core stub asserts exp_done 20 cycles after exp_start with exp_result=1024'h8 -> m_valid in the next cycle; words 0..31 read 32'h8, 0, ..., 0; m_last only on word 31.
REQ-042 m_ready toggled randomly with a 50% duty cycle during drain -> m_data stable while stalled; 32 handshakes total; s_ready=1 in the cycle after the last handshake.
REQ-043 Stub asserts exp_done during LOAD and together with exp_start -> ignored; the FSM reaches DRAIN only on a later exp_done in WAIT.
REQ-044 reset asserted after 40 load words, then 129 new words loaded -> exp_msg and exp_n reflect only the new words; exactly one exp_start.
REQ-045 Two back-to-back runs with exp=16'h0001, then 16'hFFFF -> exp_e equals 16'h0001 during run 1 and 16'hFFFF during run 2; busy low between the runs.
